regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the superscalar core.
- Provides NUM_RD combinational read ports, NUM_WR synchronous write ports and a per-register busy scoreboard.
- Sits between decode/issue, which reads operands and allocates destinations, and writeback, which writes results and clears busy.
- Register 0 is hardwired to zero.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; register count RF_N = 2**ADDR_W
NUM_RD, 3, number of read ports
NUM_WR, 2, number of write ports (writeback lanes)

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
rd_addr  in  NUM_RD x ADDR_W  read indices
rd_data  out  NUM_RD x DATA_W  read data
rd_busy  out  NUM_RD  scoreboard busy bit of each read index
wr_en  in  NUM_WR  write enables
wr_addr  in  NUM_WR x ADDR_W  write indices
wr_data  in  NUM_WR x DATA_W  write data
alloc_en  in  1  mark alloc_addr busy (destination issued)
alloc_addr  in  ADDR_W  register to mark busy
flush  in  1  clear every busy bit (pipeline flush)
any_busy  out  1  OR of all busy bits

Behaviour:
- Single clock (clk); reset is synchronous and active-high, with priority over every other input.
- Reset: all RF_N registers become 0, all busy bits become 0.
  - Outputs the cycle after reset: rd_data=0, rd_busy=0, any_busy=0.
- Writes: on posedge, for each lane i with wr_en[i]=1 and wr_addr[i]!=0, reg[wr_addr[i]] <= wr_data[i].
  - Two lanes writing the same address in one cycle: the higher lane index wins.
  - Writes to index 0 are discarded.
- Reads: combinational, zero latency.
  - rd_addr=0 always gives rd_data=0 and rd_busy=0.
  - Otherwise rd_data is the stored value, subject to the bypass rule under Optional Feature.
- Scoreboard (one busy bit per register), updated on posedge:
  - Write clears: wr_en[i] with wr_addr[i]!=0 clears busy[wr_addr[i]].
  - Alloc sets: alloc_en with alloc_addr!=0 sets busy[alloc_addr].
  - Alloc and write to the same register in the same cycle: alloc wins, so busy ends at 1 (a newer producer exists).
  - flush=1 clears all busy bits and ignores alloc_en that cycle. Writes in the same cycle still update data.
  - Register 0 is never busy.
- rd_busy reflects registered busy state; a same-cycle write does not clear it combinationally.
- any_busy is combinational from the busy register.
- Reset asserted mid-operation: in-flight writes and allocs that cycle are dropped; state returns to the reset values above.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: a read whose address matches an enabled, nonzero same-cycle write returns that wr_data, highest matching lane first. rd_busy also reads 0 for that port when the matching write is not overridden by a same-cycle alloc to the same address.
- Undefined: reads return stored contents only; written data is visible from the next cycle onward.

Decomposition:
- Package cpuDefine:
  - DType (DATA_W-bit data) and Gr (ADDR_W-bit index); rfNum equals RF_N.
  - Add constants RF_NUM_RD and RF_NUM_WR.
  - Add a typedef for the write-lane bundle (en, addr, data).
- One natural sub-module: rf_scoreboard, holding the busy vector with alloc/clear/flush priority logic, plus any_busy and per-port busy lookup.
- regfile_mp holds the storage array, the write arbitration and the bypass muxes.

Test Plan:
- Reset: write 0xDEADBEEF to r5, assert reset one cycle -> reading r5 gives 0 and any_busy=0.
- Write port conflict: lane0 writes r7=0x11, lane1 writes r7=0x22 in the same cycle -> next cycle r7 reads 0x22. Writing r0=0xFF -> r0 still reads 0.
- Bypass: lane1 writes r3=0xA5A5 while rd_addr[0]=3.
  - With RF_BYPASS_EN: rd_data[0]=0xA5A5 in that cycle.
  - Without it: the old value in that cycle, 0xA5A5 the next.
- Scoreboard: alloc r9 -> rd_busy=1 next cycle; write r9=0x5 -> busy=0 next cycle. Alloc r9 and write r9 in the same cycle -> busy stays 1.
- Flush: allocate r1, r2, r31, then assert flush together with alloc r4 -> all busy bits 0 and any_busy=0 next cycle; register data unchanged.
- Read port independence: all three ports read r0, r7 and r3 in the same cycle -> 0, 0x22 and 0xA5A5 respectively, each with the correct busy bit.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared register file types and default sizing
package cpuDefine;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int rfNum     = 2 ** RF_ADDR_W;
  localparam int RF_NUM_RD = 3;
  localparam int RF_NUM_WR = 2;

  typedef logic [RF_DATA_W-1:0] DType;
  typedef logic [RF_ADDR_W-1:0] Gr;

  // One writeback lane as presented to the register file
  typedef struct packed {
    logic en;
    Gr    addr;
    DType data;
  } wr_lane_t;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// rtl/regfile_mp_scoreboard.sv - per-register busy bits with alloc/clear/flush priority
module rf_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 3,
  parameter int NUM_WR = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr,
  input  logic                           alloc_en,
  input  logic [ADDR_W-1:0]              alloc_addr,
  input  logic                           flush,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD-1:0]              rd_busy,
  output logic                           any_busy
);

  localparam int RF_N = 2 ** ADDR_W;

  logic [RF_N-1:0] busy;
  logic [RF_N-1:0] busy_nxt;

  // Writebacks clear first, then flush wipes everything or an alloc re-marks
  // its destination (newer producer outranks a completing older one).
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en[i]) busy_nxt[wr_addr[i]] = 1'b0;
    end
    if (flush) busy_nxt = '0;
    else if (alloc_en) busy_nxt[alloc_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Busy state register, cleared by reset ahead of any same-cycle update
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  // Registered busy lookup per read port; r0 is never set so it reads 0
  always_comb begin
    any_busy = |busy;
    for (int p = 0; p < NUM_RD; p++) rd_busy[p] = busy[rd_addr[p]];
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with busy scoreboard; RF_BYPASS_EN enables write-to-read bypass
module regfile_mp
  import cpuDefine::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = RF_NUM_RD,
  parameter int NUM_WR = RF_NUM_WR
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
  input  logic                           alloc_en,
  input  logic [ADDR_W-1:0]              alloc_addr,
  input  logic                           flush,
  output logic                           any_busy
);

  localparam int RF_N = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [RF_N];
  logic [NUM_WR-1:0] wr_live;
  logic              alloc_live;
  logic [NUM_RD-1:0] sb_busy;

  // A lane only counts when enabled and not aimed at the hardwired zero register
  always_comb begin
    alloc_live = alloc_en && (alloc_addr != '0);
    for (int i = 0; i < NUM_WR; i++) wr_live[i] = wr_en[i] && (wr_addr[i] != '0);
  end

  // Storage update; lanes applied in ascending order so the highest lane wins a conflict
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < RF_N; r++) mem[r] <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_live[i]) mem[wr_addr[i]] <= wr_data[i];
      end
    end
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_live),
    .wr_addr    (wr_addr),
    .alloc_en   (alloc_live),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .rd_addr    (rd_addr),
    .rd_busy    (sb_busy),
    .any_busy   (any_busy)
  );

  // Combinational read ports with optional same-cycle bypass; r0 forced to zero/idle
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data[p] = mem[rd_addr[p]];
      rd_busy[p] = sb_busy[p];
`ifdef RF_BYPASS_EN
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_live[i] && (wr_addr[i] == rd_addr[p])) begin
          rd_data[p] = wr_data[i];
          // A same-cycle alloc to this register means a newer producer is pending
          if (!(alloc_live && !flush && (alloc_addr == rd_addr[p]))) rd_busy[p] = 1'b0;
        end
      end
`endif
      if (rd_addr[p] == '0) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - table-driven self-checking bench for regfile_mp
module tb_regfile_mp;
  import cpuDefine::*;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                 clk;
  logic                 reset;
  logic [2:0][4:0]      rd_addr;
  logic [2:0][31:0]     rd_data;
  logic [2:0]           rd_busy;
  logic [1:0]           wr_en;
  logic [1:0][4:0]      wr_addr;
  logic [1:0][31:0]     wr_data;
  logic                 alloc_en;
  logic [4:0]           alloc_addr;
  logic                 flush;
  logic                 any_busy;

  regfile_mp dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .any_busy   (any_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            nm;
    logic             rst;
    wr_lane_t [1:0]   ln;
    logic             ae;
    logic [4:0]       aa;
    logic             fl;
    logic [2:0][4:0]  ra;
    logic [2:0][31:0] ed;
    logic [2:0]       eb;
    logic             eany;
  } vec_t;

  vec_t rows[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic v(input string nm, input int rst,
                   input int we0, input int wa0, input logic [31:0] wd0,
                   input int we1, input int wa1, input logic [31:0] wd1,
                   input int ae, input int aa, input int fl,
                   input int ra0, input int ra1, input int ra2,
                   input logic [31:0] ed0, input logic [31:0] ed1, input logic [31:0] ed2,
                   input int eb, input int eany);
    vec_t r;
    r.nm = nm;
    r.rst = 1'(rst);
    r.ln[0].en = 1'(we0); r.ln[0].addr = 5'(wa0); r.ln[0].data = wd0;
    r.ln[1].en = 1'(we1); r.ln[1].addr = 5'(wa1); r.ln[1].data = wd1;
    r.ae = 1'(ae); r.aa = 5'(aa); r.fl = 1'(fl);
    r.ra[0] = 5'(ra0); r.ra[1] = 5'(ra1); r.ra[2] = 5'(ra2);
    r.ed[0] = ed0; r.ed[1] = ed1; r.ed[2] = ed2;
    r.eb = 3'(eb);
    r.eany = 1'(eany);
    rows.push_back(r);
  endtask

  task automatic chk(input string lbl, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", lbl, act, exp);
    end
  endtask

  // Drive each row at the falling edge, queue its expectation, sample mid-low-phase
  task automatic run_rows();
    vec_t e;
    foreach (rows[k]) begin
      @(negedge clk);
      reset      = rows[k].rst;
      for (int i = 0; i < 2; i++) begin
        wr_en[i]   = rows[k].ln[i].en;
        wr_addr[i] = rows[k].ln[i].addr;
        wr_data[i] = rows[k].ln[i].data;
      end
      alloc_en   = rows[k].ae;
      alloc_addr = rows[k].aa;
      flush      = rows[k].fl;
      rd_addr    = rows[k].ra;
      exp_q.push_back(rows[k]);
      #2;
      e = exp_q.pop_front();
      n_vec++;
      for (int p = 0; p < 3; p++) begin
        chk($sformatf("%s rd_data[%0d]", e.nm, p), rd_data[p], e.ed[p]);
        chk($sformatf("%s rd_busy[%0d]", e.nm, p), {31'd0, rd_busy[p]}, {31'd0, e.eb[p]});
      end
      chk($sformatf("%s any_busy", e.nm), {31'd0, any_busy}, {31'd0, e.eany});
    end
    rows.delete();
  endtask

  initial begin
    reset = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0; rd_addr = '0;
    @(negedge clk);
    @(negedge clk);

    //  name          rst we0 wa0 wd0            we1 wa1 wd1       ae aa fl  ra0 ra1 ra2  ed0..ed2                                              eb               any
    v("rst_state",    0,  0,0,0,                 0,0,0,            0,0,0,    5,7,3,    0, 0, 0,                                                    0,               0);
    v("wr_r5",        0,  1,5,32'hDEADBEEF,      0,0,0,            0,0,0,    5,0,0,    BYP ? 32'hDEADBEEF : 32'h0, 0, 0,                        0,               0);
    v("r5_stored",    0,  0,0,0,                 0,0,0,            1,6,0,    5,0,0,    32'hDEADBEEF, 0, 0,                                         0,               0);
    v("rst_mid",      1,  1,7,32'h99,            0,0,0,            1,8,0,    5,6,0,    32'hDEADBEEF, 0, 0,                                         2,               1);
    v("after_rst",    0,  0,0,0,                 0,0,0,            0,0,0,    5,7,8,    0, 0, 0,                                                    0,               0);
    v("wr_conflict",  0,  1,7,32'h11,            1,7,32'h22,       0,0,0,    7,0,0,    BYP ? 32'h22 : 32'h0, 0, 0,                                 0,               0);
    v("wr_r0",        0,  1,0,32'hFF,            0,0,0,            0,0,0,    0,7,0,    0, 32'h22, 0,                                               0,               0);
    v("r0_zero",      0,  0,0,0,                 0,0,0,            0,0,0,    0,7,0,    0, 32'h22, 0,                                               0,               0);
    v("bypass_r3",    0,  0,0,0,                 1,3,32'hA5A5,     0,0,0,    3,0,0,    BYP ? 32'hA5A5 : 32'h0, 0, 0,                               0,               0);
    v("r3_next",      0,  0,0,0,                 0,0,0,            1,9,0,    3,0,0,    32'hA5A5, 0, 0,                                             0,               0);
    v("busy_r9",      0,  1,9,32'h5,             0,0,0,            0,0,0,    9,0,0,    BYP ? 32'h5 : 32'h0, 0, 0,                                  BYP ? 0 : 1,     1);
    v("r9_clear",     0,  0,0,0,                 1,9,32'h6,        1,9,0,    9,0,0,    BYP ? 32'h6 : 32'h5, 0, 0,                                  0,               0);
    v("alloc_wins",   0,  1,9,32'h7,             0,0,0,            1,9,0,    9,0,0,    BYP ? 32'h7 : 32'h6, 0, 0,                                  1,               1);
    v("alloc_r1",     0,  0,0,0,                 0,0,0,            1,1,0,    9,0,0,    32'h7, 0, 0,                                                1,               1);
    v("alloc_r2",     0,  0,0,0,                 0,0,0,            1,2,0,    1,9,0,    0, 32'h7, 0,                                                3,               1);
    v("alloc_r31",    0,  0,0,0,                 0,0,0,            1,31,0,   2,1,0,    0, 0, 0,                                                    3,               1);
    v("flush",        0,  1,2,32'h77,            0,0,0,            1,4,1,    31,2,4,   0, BYP ? 32'h77 : 32'h0, 0,                                 BYP ? 1 : 3,     1);
    v("post_flush",   0,  0,0,0,                 0,0,0,            1,7,0,    7,2,4,    32'h22, 32'h77, 0,                                          0,               0);
    v("ports_indep",  0,  0,0,0,                 0,0,0,            0,0,0,    0,7,3,    0, 32'h22, 32'hA5A5,                                        2,               1);
    v("alloc_r0",     0,  1,7,32'h33,            0,0,0,            1,0,0,    0,7,3,    0, BYP ? 32'h33 : 32'h22, 32'hA5A5,                         BYP ? 0 : 2,     1);
    v("r0_not_busy",  0,  0,0,0,                 0,0,0,            0,0,0,    0,7,3,    0, 32'h33, 32'hA5A5,                                        0,               0);
    run_rows();

    // Reset held over two cycles with writes and allocs in flight
    v("rst_hold_a",   1,  1,10,32'h1234,         0,0,0,            1,11,0,   10,3,0,   BYP ? 32'h1234 : 32'h0, 32'hA5A5, 0,                        0,               0);
    v("rst_hold_b",   1,  0,0,0,                 1,3,32'h4321,     1,12,0,   10,3,11,  0, BYP ? 32'h4321 : 32'h0, 0,                               0,               0);
    v("rst_release",  0,  0,0,0,                 0,0,0,            0,0,0,    10,3,12,  0, 0, 0,                                                    0,               0);
    run_rows();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
